// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA framebuffer write path.
package vga_pkg;

    typedef enum logic {ARB, OWN} vga_arb_state_e;

    localparam int VGA_ARB_DROP_CNT_W = 16;

endpackage

// File: rtl/vga_rr_pick.sv
// Combinational rotating-priority encoder: the first valid requester
// found when scanning upward from last+1 (mod N_REQ).
module vga_rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int k;

    // NOTE: every output gets a default before the scan so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        k      = 0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(last) + 1 + i) % N_REQ;
            if (!any && valid[k]) begin
                onehot[k] = 1'b1;
                idx       = IDX_W'(k);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_fb_wr_arbiter.sv
// Round-robin arbiter sharing the vga_top framebuffer write port between
// pixel producers, with burst limiting, resolution clipping and a held output register.
module vga_fb_wr_arbiter
    import vga_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int X_W       = 11,
    parameter int Y_W       = 11,
    parameter int COLOR_W   = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic [X_W-1:0]                res_x_i,
    input  logic [Y_W-1:0]                res_y_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ*X_W-1:0]          req_x_i,
    input  logic [N_REQ*Y_W-1:0]          req_y_i,
    input  logic [N_REQ*COLOR_W-1:0]      req_color_i,
    output logic                          we_o,
    output logic [X_W-1:0]                addr_x_o,
    output logic [Y_W-1:0]                addr_y_o,
    output logic [COLOR_W-1:0]            color_o,
    input  logic                          wr_gnt_i,
    output logic [N_REQ-1:0]              grant_o,
    output logic [VGA_ARB_DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [IDX_W-1:0]   LAST_RST   = IDX_W'(N_REQ - 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

    vga_arb_state_e       state_q, state_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [BURST_W-1:0]   burst_q, burst_d;

    logic [N_REQ-1:0]     pick_onehot;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic [COLOR_W-1:0]   sel_color;
    logic                 owner_valid;
    logic                 drain, can_load, accept, in_range;

    logic                 we_q;
    logic [X_W-1:0]       x_q;
    logic [Y_W-1:0]       y_q;
    logic [COLOR_W-1:0]   color_q;
    logic [VGA_ARB_DROP_CNT_W-1:0] drop_q;

    vga_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .valid  (req_valid_i),
        .last   (last_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        sel_x       = '0;
        sel_y       = '0;
        sel_color   = '0;
        owner_valid = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                sel_x       = req_x_i[k*X_W +: X_W];
                sel_y       = req_y_i[k*Y_W +: Y_W];
                sel_color   = req_color_i[k*COLOR_W +: COLOR_W];
                owner_valid = req_valid_i[k];
            end
        end
    end

    // The output slot can take new data when empty or when it drains this cycle.
    assign drain       = we_q && wr_gnt_i;
    assign can_load    = !we_q || drain;
    assign accept      = (state_q == OWN) && owner_valid && can_load;
    assign in_range    = (sel_x < res_x_i) && (sel_y < res_y_i);
    assign req_ready_o = ((state_q == OWN) && can_load) ? grant_q : '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        burst_d = burst_q;
        case (state_q)
            ARB: begin
                if (pick_any) begin
                    state_d = OWN;
                    grant_d = pick_onehot;
                    owner_d = pick_idx;
                    burst_d = '0;
                end
            end
            OWN: begin
                if (!owner_valid || (accept && burst_q == BURST_LAST)) begin
                    state_d = ARB;
                    grant_d = '0;
                    last_d  = owner_q;
                end else if (accept) begin
                    burst_d = burst_q + BURST_W'(1);
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= ARB;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= LAST_RST;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            we_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
        end else if (accept && in_range) begin
            we_q    <= 1'b1;
            x_q     <= sel_x;
            y_q     <= sel_y;
            color_q <= sel_color;
        end else if (drain) begin
            we_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            drop_q <= '0;
        end else if (accept && !in_range && drop_q != '1) begin
            drop_q <= drop_q + VGA_ARB_DROP_CNT_W'(1);
        end
    end

    assign we_o       = we_q;
    assign addr_x_o   = x_q;
    assign addr_y_o   = y_q;
    assign color_o    = color_q;
    assign grant_o    = grant_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: doc/vga_fb_wr_arbiter.md
# vga_fb_wr_arbiter

Round-robin arbiter that shares the single framebuffer write port of `vga_top` (`addr_x_i`, `addr_y_i`, `color_i`, `we_i`, `wr_gnt_o`) between several pixel producers, e.g. pattern generator, sprite mover and debug writer.
- Grants one requester at a time, with bounded burst length.
- Clips writes outside the active resolution.
- Presents a registered, gnt-held write request downstream.
- Sits in the VGA pixel-clock domain between the producers and `vga_top`.

## Interface
- `N_REQ`, default 3: number of requesters (2..8).
- `X_W`, default 11: x coordinate width.
- `Y_W`, default 11: y coordinate width.
- `COLOR_W`, default 2: pixel color width.
- `MAX_BURST`, default 16: accepted writes per grant before forced re-arbitration (1..256).
- `clk_i`  in  1  pixel clock; one clock only.
- `arstn_i`  in  1  reset, asynchronous, active-low.
- `res_x_i`  in  X_W  active width (800 or 1280); quasi-static.
- `res_y_i`  in  Y_W  active height (600 or 1024); quasi-static.
- `req_valid_i`  in  N_REQ  per-requester write valid.
- `req_ready_o`  out  N_REQ  per-requester accept; at most one bit high.
- `req_x_i`  in  N_REQ×X_W  packed x coordinates, requester 0 in LSBs.
- `req_y_i`  in  N_REQ×Y_W  packed y coordinates.
- `req_color_i`  in  N_REQ×COLOR_W  packed colors.
- `we_o`  out  1  downstream write request (to `we_i`).
- `addr_x_o`  out  X_W  downstream x.
- `addr_y_o`  out  Y_W  downstream y.
- `color_o`  out  COLOR_W  downstream color.
- `wr_gnt_i`  in  1  downstream accept (from `wr_gnt_o`).
- `grant_o`  out  N_REQ  one-hot current owner; 0 when idle.
- `drop_cnt_o`  out  16  saturating count of clipped writes.

## Operation
- Upstream handshake: a transfer occurs when `req_valid_i[k] && req_ready_o[k]`. Downstream handshake: a transfer occurs when `we_o && wr_gnt_i`.
- FSM states are `ARB` and `OWN`.
- `ARB`:
  - Pick the first `k` with `req_valid_i[k]`, scanning from `last_owner+1` mod `N_REQ`.
  - Register `grant_o`, clear the burst counter and go to `OWN`.
  - No valid request: stay in `ARB`. All `req_ready_o` are 0 in `ARB`.
- `OWN`:
  - `req_ready_o[owner] = out_empty || (we_o && wr_gnt_i)`.
  - On an accept, `burst_cnt++`.
  - In-range accept: the output register loads x/y/color and `we_o` is set.
  - Out-of-range accept (`x >= res_x_i` or `y >= res_y_i`): the write is consumed. The output register is not loaded, and `drop_cnt_o` increments, saturating at 0xFFFF.
- Leaving `OWN` for `ARB`, with `last_owner <= owner` and `grant_o <= 0`, happens in either case:
  - owner's `req_valid_i` is low;
  - an accept occurs with `burst_cnt == MAX_BURST-1`.
- The output register drains independently of the FSM. `we_o` clears on a downstream transfer unless it is reloaded in the same cycle.
- Single requester, continuously valid: it is re-granted after each burst, paying one `ARB` bubble cycle.

## Timing
- Reset values:
  - `we_o` = 0; `addr_x_o`, `addr_y_o`, `color_o` = 0.
  - `grant_o` = 0; `req_ready_o` = 0; `drop_cnt_o` = 0.
  - FSM in `ARB`; `last_owner` = `N_REQ-1`, so requester 0 wins first.
- Grant latency: valid seen in `ARB` at cycle t → `grant_o` at t+1 → first `req_ready_o` at t+1, if the output register is empty.
- Write latency: accept at cycle t → `we_o` with that data at t+1.
- Hold rule: while `we_o && !wr_gnt_i`, `we_o`/`addr_*_o`/`color_o` stay stable and `req_ready_o` = 0.
- Throughput: with `wr_gnt_i` held high, one write per cycle inside a burst, with no bubble between consecutive accepts.
- Simultaneous drain + load: a downstream transfer and an upstream accept in the same cycle replace the register contents with no gap.
- Reset mid-operation: a pending `we_o` write is discarded, and the grant and burst state are lost.
- Changing `res_x_i`/`res_y_i` takes effect on the next accept's clip check.

## Structure
- Add to `vga_pkg`:
  - `typedef enum logic {ARB, OWN} vga_arb_state_e`;
  - constant `VGA_ARB_DROP_CNT_W = 16`.
- One sub-module: `vga_rr_pick`, a combinational rotate-priority-encoder with inputs `valid`, `last` and outputs `onehot`, `idx`, `any`.
- FSM, burst counter, output register and drop counter live in the top.

## Test plan
- Reset, then req0 valid with (10,20,1) and `wr_gnt_i`=1 → `grant_o`=001 at cycle 1, `req_ready_o[0]` at cycle 1, `we_o` with (10,20,1) at cycle 2.
- req0 and req1 both valid continuously, `MAX_BURST`=4 → owner alternates 0,1,0,… Each owner is accepted exactly 4 times per grant, with one idle `ARB` cycle between grants.
- `wr_gnt_i` held low for 5 cycles during a burst → `we_o`/address stable, `req_ready_o`=0. Release `wr_gnt_i` → one transfer per cycle resumes, with no data lost or duplicated.
- Resolution 800×600, write (800,5) then (799,599) → first write is dropped (`drop_cnt_o`=1, no `we_o`); second is written.
- Owner drops valid after 2 accepts, with req2 pending → `ARB` next cycle, then `grant_o`=100. `last_owner` rotates correctly.
- `arstn_i` pulsed low while `we_o`=1 and `grant_o`=010 → all outputs 0 immediately. After release, requester 0 has priority.
